out_capture: RTL and testbench

OUT_CAPTURE -- requirements
Module: out_capture

---
 rtl/out_capture.sv | 158 +++++++++++++++
 tb/tb_out_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/out_capture.sv
// ----------------------------------------------------------------------------
// out_capture
//   Captures words emitted by a CPU output strobe into a show-ahead FIFO that a
//   host drains with a valid/ready handshake. Once the CPU halts, further
//   strobes are ignored and the block reports done after the FIFO empties.
//
// Ports
//   clk         : single clock, rising edge
//   reset       : asynchronous, active-low; clears all state
//   out_signal  : CPU output strobe, one word per high cycle
//   out_data    : CPU output word, sampled with out_signal
//   halt        : CPU halted (level)
//   m_valid     : head word available to the host
//   m_data      : head word (show-ahead)
//   m_ready     : host accepts the head word this cycle
//   count       : current FIFO occupancy
//   overflow    : sticky, a word was dropped because the FIFO was full
//   drop_count  : number of dropped words, saturating at 16'hFFFF
//   done        : halt seen and FIFO fully drained
// ----------------------------------------------------------------------------
module out_capture #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           out_signal,
    input  logic [WIDTH-1:0]               out_data,
    input  logic                           halt,
    output logic                           m_valid,
    output logic [WIDTH-1:0]               m_data,
    input  logic                           m_ready,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           overflow,
    output logic [15:0]                    drop_count,
    output logic                           done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_count_q, drop_count_d;
    logic              done_q, done_d;

    // Storage is deliberately not reset; m_valid alone qualifies m_data.
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              full;
    logic              pop;
    logic              push_req;
    logic              push;
    logic              drop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        // Pop is based on the registered count, so a word pushed into an
        // empty FIFO cannot leave in the same cycle.
        pop      = (count_q != '0) && m_ready;
        push_req = (state_q == RUN) && out_signal;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        state_d      = state_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end

        unique case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // No pushes happen here, so count_d == 0 covers both the
                // last pop and the already-empty case.
                if (count_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= out_data;
        end
    end

    always_comb begin
        m_valid    = (count_q != '0);
        m_data     = mem_q[rd_ptr_q];
        count      = count_q;
        overflow   = overflow_q;
        drop_count = drop_count_q;
        done       = done_q;
    end

endmodule

// File: tb/tb_out_capture.sv
// ----------------------------------------------------------------------------
// tb_out_capture
//   Directed self-checking bench for out_capture (WIDTH=64, DEPTH=16).
// ----------------------------------------------------------------------------
module tb_out_capture;

    logic        clk;
    logic        reset;
    logic        out_signal;
    logic [63:0] out_data;
    logic        halt;
    logic        m_valid;
    logic [63:0] m_data;
    logic        m_ready;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_count;
    logic        done;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [63:0] q [$];
    int          pushed;
    int          cyc;
    logic        os;
    logic        rdy;

    out_capture #(
        .WIDTH(64),
        .DEPTH(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .out_signal (out_signal),
        .out_data   (out_data),
        .halt       (halt),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    // Drive inputs, advance one rising edge, settle 1 time unit past it.
    task automatic step(input logic s, input logic [63:0] d, input logic h, input logic r);
        out_signal = s;
        out_data   = d;
        halt       = h;
        m_ready    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        out_signal = 1'b0;
        halt       = 1'b0;
        m_ready    = 1'b0;
        reset      = 1'b0;
        #2;
        reset      = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        out_signal = 1'b0;
        out_data   = '0;
        halt       = 1'b0;
        m_ready    = 1'b0;

        // Reset state, before any clock edge
        #2;
        check("rst_m_valid",    64'(m_valid),    64'h0);
        check("rst_count",      64'(count),      64'h0);
        check("rst_overflow",   64'(overflow),   64'h0);
        check("rst_drop_count", 64'(drop_count), 64'h0);
        check("rst_done",       64'(done),       64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Three strobes held, then drained in order
        step(1'b1, 64'h11, 1'b0, 1'b0);
        check("lat_m_valid", 64'(m_valid), 64'h1);
        check("lat_m_data",  m_data,        64'h11);
        step(1'b1, 64'h22, 1'b0, 1'b0);
        step(1'b1, 64'h33, 1'b0, 1'b0);
        check("basic_count",  64'(count), 64'h3);
        check("basic_m_data", m_data,     64'h11);
        step(1'b0, 64'hDEAD, 1'b0, 1'b0);
        check("hold_m_data", m_data, 64'h11);
        m_ready = 1'b1;
        check("pop0_data", m_data, 64'h11);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        check("pop1_data", m_data, 64'h22);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        check("pop2_data", m_data, 64'h33);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        check("basic_empty_valid", 64'(m_valid), 64'h0);
        check("basic_empty_count", 64'(count),   64'h0);

        // 18 strobes into 16 entries: two dropped
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0);
        end
        check("ovf_count",      64'(count),      64'd16);
        check("ovf_overflow",   64'(overflow),   64'h1);
        check("ovf_drop_count", 64'(drop_count), 64'h2);
        out_signal = 1'b0;
        m_ready    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain_data", m_data, 64'h100 + 64'(i));
            step(1'b0, 64'h0, 1'b0, 1'b1);
        end
        check("ovf_drained_count", 64'(count), 64'h0);
        check("ovf_sticky",        64'(overflow), 64'h1);

        // Reset mid-operation discards stored words; first push lands in entry 0
        step(1'b1, 64'hAAA1, 1'b0, 1'b0);
        step(1'b1, 64'hAAA2, 1'b0, 1'b0);
        pulse_reset();
        check("mid_rst_count",    64'(count),      64'h0);
        check("mid_rst_overflow", 64'(overflow),   64'h0);
        check("mid_rst_drops",    64'(drop_count), 64'h0);
        @(posedge clk);
        #1;
        step(1'b1, 64'h5555, 1'b0, 1'b0);
        check("mid_rst_first_count", 64'(count), 64'h1);
        check("mid_rst_first_data",  m_data,     64'h5555);

        // Full FIFO with simultaneous pop and push: no drop
        pulse_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 64'h200 + 64'(i), 1'b0, 1'b0);
        end
        check("full_count", 64'(count), 64'd16);
        step(1'b1, 64'hBEEF, 1'b0, 1'b1);
        check("full_pp_count",    64'(count),      64'd16);
        check("full_pp_overflow", 64'(overflow),   64'h0);
        check("full_pp_drops",    64'(drop_count), 64'h0);
        check("full_pp_head",     m_data,          64'h201);
        for (int i = 1; i < 16; i++) begin
            check("full_pp_order", m_data, 64'h200 + 64'(i));
            step(1'b0, 64'h0, 1'b0, 1'b1);
        end
        check("full_pp_last", m_data, 64'hBEEF);
        step(1'b0, 64'h0, 1'b0, 1'b1);
        check("full_pp_empty", 64'(m_valid), 64'h0);

        // 40 words with random m_ready, crossing pointer wrap
        pulse_reset();
        @(posedge clk);
        #1;
        q.delete();
        pushed = 0;
        cyc    = 0;
        while ((pushed < 40 || q.size() != 0) && cyc < 400) begin
            os  = (pushed < 40) && (q.size() < 16);
            rdy = 1'($urandom_range(0, 1));
            out_signal = os;
            out_data   = 64'h3000 + 64'(pushed);
            m_ready    = rdy;
            #1;
            check("wrap_valid", 64'(m_valid), 64'(q.size() != 0));
            if (rdy && q.size() != 0) begin
                check("wrap_data", m_data, q[0]);
                void'(q.pop_front());
            end
            if (os) begin
                q.push_back(64'h3000 + 64'(pushed));
                pushed++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("wrap_in_budget", 64'(cyc < 400), 64'h1);
        check("wrap_drops",     64'(drop_count), 64'h0);
        check("wrap_count",     64'(count),      64'h0);

        // Halt with the final strobe
        pulse_reset();
        @(posedge clk);
        #1;
        step(1'b1, 64'hAB, 1'b1, 1'b0);
        check("halt_count", 64'(count), 64'h1);
        check("halt_done0", 64'(done),  64'h0);
        out_signal = 1'b1;
        out_data   = 64'hCC;
        halt       = 1'b0;
        m_ready    = 1'b1;
        #1;
        check("halt_valid", 64'(m_valid), 64'h1);
        check("halt_data",  m_data,       64'hAB);
        step(1'b1, 64'hCC, 1'b0, 1'b1);
        check("halt_done1",  64'(done),     64'h1);
        check("halt_empty",  64'(count),    64'h0);
        check("halt_mvalid", 64'(m_valid),  64'h0);
        step(1'b1, 64'hDD, 1'b0, 1'b1);
        check("halt_ignored_count", 64'(count),      64'h0);
        check("halt_ignored_drops", 64'(drop_count), 64'h0);
        check("halt_ignored_ovf",   64'(overflow),   64'h0);
        check("halt_terminal",      64'(done),       64'h1);

        // Halt with empty FIFO, then asynchronous reset clears done
        pulse_reset();
        @(posedge clk);
        #1;
        step(1'b0, 64'h0, 1'b1, 1'b0);
        check("empty_halt_edge1", 64'(done), 64'h0);
        step(1'b0, 64'h0, 1'b1, 1'b0);
        check("empty_halt_edge2", 64'(done), 64'h1);
        reset = 1'b0;
        #1;
        check("async_rst_done", 64'(done), 64'h0);
        #1;
        reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
